// File: rtl/regfile_wb_pkg.sv
// Shared types and constants for the writeback-side register file.
package regfile_wb_pkg;
    typedef logic [31:0] u32;
    typedef logic [4:0]  creg_addr_t;

    localparam creg_addr_t REG_ZERO = 5'd0;
endpackage

// File: rtl/regfile_wb_if.sv
// Decode read ports, writeback triple and issue/stall signals of the register file.
interface regfile_wb_if;
    import regfile_wb_pkg::*;

    creg_addr_t ra1;
    creg_addr_t ra2;
    logic       use1;
    logic       use2;
    u32         rd1;
    u32         rd2;
    logic       reg_write;
    creg_addr_t write_reg;
    u32         resultW;
    logic       issue_valid;
    creg_addr_t issue_dst;
    logic       busy1;
    logic       busy2;
    logic       stall;

    modport master (
        output ra1, ra2, use1, use2, reg_write, write_reg, resultW, issue_valid, issue_dst,
        input  rd1, rd2, busy1, busy2, stall
    );

    modport slave (
        input  ra1, ra2, use1, use2, reg_write, write_reg, resultW, issue_valid, issue_dst,
        output rd1, rd2, busy1, busy2, stall
    );
endinterface

// File: rtl/regfile_wb_reg_scoreboard.sv
// Per-register pending bits for outstanding long-latency producers.
module reg_scoreboard
    import regfile_wb_pkg::*;
#(
    parameter int unsigned NREG = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       set_en,
    input  creg_addr_t set_idx,
    input  logic       clr_en,
    input  creg_addr_t clr_idx,
    input  creg_addr_t q1_idx,
    output logic       q1_pend,
    input  creg_addr_t q2_idx,
    output logic       q2_pend
);
    logic [NREG-1:0] pending;
    logic [31:0]     pend_full;

    // Set is tested first: a new producer issued in the writeback cycle stays outstanding.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            for (int unsigned i = 1; i < NREG; i++) begin
                if (set_en && set_idx == creg_addr_t'(i))
                    pending[i] <= 1'b1;
                else if (clr_en && clr_idx == creg_addr_t'(i))
                    pending[i] <= 1'b0;
            end
            pending[0] <= 1'b0;
        end
    end

    // Zero-extended so addresses at or above NREG always query as idle.
    assign pend_full = 32'(pending);
    assign q1_pend   = pend_full[q1_idx];
    assign q2_pend   = pend_full[q2_idx];
endmodule

// File: rtl/regfile_wb.sv
// Architectural register file with optional write-before-read bypass and load-use scoreboard.
module regfile_wb
    import regfile_wb_pkg::*;
#(
    parameter int unsigned NREG   = 32,
    parameter int unsigned BYPASS = 1
) (
    input  logic         clk,
    input  logic         reset,
    regfile_wb_if.slave  bus
);
    u32   regs [NREG];
    u32   rd1_c;
    u32   rd2_c;
    logic wr_hit1;
    logic wr_hit2;
    logic pend1;
    logic pend2;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++)
                regs[i] <= '0;
        end else if (bus.reg_write && bus.write_reg != REG_ZERO) begin
            for (int unsigned i = 1; i < NREG; i++)
                if (bus.write_reg == creg_addr_t'(i))
                    regs[i] <= bus.resultW;
        end
    end

    assign wr_hit1 = (BYPASS != 0) && bus.reg_write && (bus.write_reg == bus.ra1);
    assign wr_hit2 = (BYPASS != 0) && bus.reg_write && (bus.write_reg == bus.ra2);

    // Only in-range nonzero addresses match the loop, so index 0 and out-of-range reads stay 0.
    always_comb begin
        rd1_c = '0;
        rd2_c = '0;
        for (int unsigned i = 1; i < NREG; i++) begin
            if (bus.ra1 == creg_addr_t'(i))
                rd1_c = wr_hit1 ? bus.resultW : regs[i];
            if (bus.ra2 == creg_addr_t'(i))
                rd2_c = wr_hit2 ? bus.resultW : regs[i];
        end
    end

    reg_scoreboard #(
        .NREG (NREG)
    ) u_scoreboard (
        .clk     (clk),
        .reset   (reset),
        .set_en  (bus.issue_valid),
        .set_idx (bus.issue_dst),
        .clr_en  (bus.reg_write),
        .clr_idx (bus.write_reg),
        .q1_idx  (bus.ra1),
        .q1_pend (pend1),
        .q2_idx  (bus.ra2),
        .q2_pend (pend2)
    );

    assign bus.rd1   = rd1_c;
    assign bus.rd2   = rd2_c;
    assign bus.busy1 = pend1 & ~wr_hit1;
    assign bus.busy2 = pend2 & ~wr_hit2;
    assign bus.stall = (bus.busy1 & bus.use1) | (bus.busy2 & bus.use2);
endmodule

// File: doc/regfile_wb.md
Name: regfile_wb

Overview:
- Architectural register file that sits at the far end of the writeback interface.
- Consumes the writeback triple (reg_write, write_reg, resultW) and serves two combinational read ports to decode.
- Holds a per-register pending scoreboard: decode marks a destination pending when it issues a multi-cycle producer (load); the matching writeback clears it.
- Generates the decode stall request from the scoreboard.

Parameters:
- NREG, 32, number of architectural registers; index 0 is hardwired zero.
- BYPASS, 1, 1 = same-cycle write is forwarded to read ports (write-before-read); 0 = reads see array contents only.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- ra1  in  5  read address, port 1 (creg_addr_t)
- ra2  in  5  read address, port 2 (creg_addr_t)
- use1  in  1  decode actually consumes rd1 this cycle
- use2  in  1  decode actually consumes rd2 this cycle
- rd1  out  32  read data, port 1 (u32)
- rd2  out  32  read data, port 2 (u32)
- reg_write  in  1  writeback enable
- write_reg  in  5  writeback destination (creg_addr_t)
- resultW  in  32  writeback data (u32)
- issue_valid  in  1  decode issues a long-latency producer this cycle
- issue_dst  in  5  destination of that producer
- busy1  out  1  ra1 is pending
- busy2  out  1  ra2 is pending
- stall  out  1  (busy1 & use1) | (busy2 & use2)

Behaviour:
- Reset (sync, reset=1 at posedge clk):
  - All NREG registers are cleared to 0.
  - All pending bits are cleared.
  - While reset is high, rd1/rd2 read the (zeroed) array, and busy1/busy2/stall are 0 after the first reset edge.
  - Reset wins over any simultaneous write or issue.
- Write:
  - At posedge clk, if reg_write=1 and write_reg!=0, then reg[write_reg] <= resultW.
  - A write to index 0 is dropped; reg[0] always reads 0.
- Read (combinational, zero latency):
  - rdN = 0 if raN==0.
  - Otherwise, if BYPASS=1 and reg_write=1 and write_reg==raN, then rdN = resultW.
  - Otherwise rdN = reg[raN].
  - The two ports are independent; ra1==ra2 is legal and both ports return identical data.
- Scoreboard: one pending bit per register; bit 0 is never set.
  - At posedge, if reg_write=1 and write_reg!=0: clear pending[write_reg].
  - At posedge, if issue_valid=1 and issue_dst!=0: set pending[issue_dst].
  - Same register set and cleared in the same cycle: set wins (the new producer is still outstanding).
  - Set on an already-pending register: stays set (no counting; decode must not issue two outstanding producers to one register).
- busyN (combinational):
  - busyN = pending[raN].
  - Exception: when BYPASS=1 and this cycle's write clears raN, busyN = 0, so the consumer proceeds with the bypassed data.
  - raN==0 gives busyN=0.
- Stall: purely combinational from busy and use; no registered state.
- Width rules:
  - Addresses are 5 bits; NREG must be ≤ 32.
  - Addresses ≥ NREG read 0, are never busy, and writes to them are dropped.

Decomposition:
- Shared package (common):
  - u32
  - creg_addr_t
  - constant REG_ZERO = 5'd0
- Sub-module reg_scoreboard (clk, reset, set_en/set_idx, clr_en/clr_idx, two query ports) holds the pending vector and its set-wins rule.
- regfile_wb instantiates reg_scoreboard alongside the data array and the bypass muxes.

Test Plan:
- Reset then read: assert reset 2 cycles, ra1=5, ra2=31 → rd1=0, rd2=0, busy1=busy2=stall=0.
- Write then read: reg_write=1, write_reg=3, resultW=0xDEADBEEF for 1 cycle → next cycle ra1=3 gives rd1=0xDEADBEEF. A write to 0 with 0x12345678 → ra2=0 gives rd2=0.
- Same-cycle bypass: reg_write=1, write_reg=7, resultW=0xA5A5A5A5 with ra1=ra2=7 in the same cycle → rd1=rd2=0xA5A5A5A5 combinationally (BYPASS=1); with BYPASS=0 → old value.
- Load-use stall: issue_valid=1, issue_dst=9 → next cycle ra1=9, use1=1 gives busy1=1, stall=1. Then writeback to 9 with 0x00000042 → same cycle busy1=0, stall=0, rd1=0x00000042; next cycle pending[9]=0.
- Set-wins collision: pending[4]=1; in one cycle reg_write=1/write_reg=4 and issue_valid=1/issue_dst=4 → next cycle busy for ra=4 is 1 and reg[4] holds the written value. With use1=0 → stall=0 despite busy1=1.
- Reset mid-operation: pending[2,6] set and reg[6]=0x11 → assert reset together with reg_write to 6 → all pending 0, reg[6]=0.
